// File: rtl/cfg_chain_loader_if.sv
// Config word stream between the SoC-side bridge (master) and the chain loader (slave).
interface cfg_chain_loader_if #(
  parameter int WORD_W = 32
);
  logic              word_valid;
  logic [WORD_W-1:0] word_data;
  logic              word_ready;

  modport master (output word_valid, output word_data, input word_ready);
  modport slave  (input word_valid, input word_data, output word_ready);
endinterface

// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader: serialises parallel config words LSB-first onto a tile
// column's config chain, then strobes cset once chain_len bits are shifted.
// Optional readback capture of the chain's far end: CFG_CHAIN_LOADER_READBACK_EN.
module cfg_chain_loader #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_W-1:0]     chain_len,
  cfg_chain_loader_if.slave    word,
  output logic                 cen,
  output logic                 shift_out,
  output logic                 cset,
  output logic                 busy,
  output logic                 done
`ifdef CFG_CHAIN_LOADER_READBACK_EN
  ,
  input  logic                 chain_in,
  output logic                 rb_valid,
  output logic [WORD_W-1:0]    rb_data
`endif
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] SET   = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]        state, state_nxt;
  logic [CNT_W-1:0]  remaining;
  logic [IDX_W-1:0]  bit_idx;
  logic [WORD_W-1:0] shreg;
  logic              start_ok, accept, last_bit, word_end;

  // Handshake and shift-exit qualifiers
  always_comb begin
    start_ok = start && !abort;
    accept   = (state == FETCH) && word.word_valid;
    last_bit = (remaining == CNT_W'(1));
    word_end = (bit_idx == IDX_W'(WORD_W - 1));
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = (chain_len == '0) ? SET : FETCH;
      FETCH:   if (accept) state_nxt = SHIFT;
      SHIFT: begin
        if (last_bit)      state_nxt = SET;
        else if (word_end) state_nxt = FETCH;
      end
      SET:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Bit counter, word index and shift register; SHIFT exit uses the pre-decrement count
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
    end else begin
      case (state)
        IDLE: if (start_ok) remaining <= chain_len;
        FETCH: if (accept) begin
          shreg   <= word.word_data;
          bit_idx <= '0;
        end
        SHIFT: begin
          shreg     <= shreg >> 1;
          bit_idx   <= bit_idx + IDX_W'(1);
          remaining <= remaining - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded directly from state
  always_comb begin
    word.word_ready = (state == FETCH);
    cen             = (state == SHIFT);
    shift_out       = (state == SHIFT) ? shreg[0] : 1'b0;
    cset            = (state == SET);
    done            = (state == DONE);
    busy            = (state != IDLE);
  end

`ifdef CFG_CHAIN_LOADER_READBACK_EN
  logic [WORD_W-2:0] cap;
  logic [WORD_W-1:0] cap_nxt;

  // Incoming chain bit enters at the MSB so the first-shifted bit ends at the LSB
  always_comb begin
    cap_nxt = {chain_in, cap};
  end

  // Capture register and readback strobe; a short final word is right-aligned, zero top
  always_ff @(posedge clk) begin
    if (rst) begin
      cap      <= '0;
      rb_valid <= 1'b0;
      rb_data  <= '0;
    end else begin
      rb_valid <= 1'b0;
      if (state == SHIFT) begin
        cap <= cap_nxt[WORD_W-1:1];
        if (last_bit || word_end) begin
          rb_valid <= 1'b1;
          rb_data  <= cap_nxt >> (IDX_W'(WORD_W - 1) - bit_idx);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Directed bench for cfg_chain_loader with a bit-level scoreboard on shift_out
// (and on rb_data when CFG_CHAIN_LOADER_READBACK_EN is defined).
module tb_cfg_chain_loader;
  localparam int WORD_W = 32;
  localparam int CNT_W  = 20;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] chain_len = '0;
  logic             cen, shift_out, cset, busy, done;

  cfg_chain_loader_if #(.WORD_W(WORD_W)) word_bus ();

`ifdef CFG_CHAIN_LOADER_READBACK_EN
  logic              chain_in, rb_valid;
  logic [WORD_W-1:0] rb_data;
  logic [31:0]       dly;
`endif

  cfg_chain_loader #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .chain_len (chain_len),
    .word      (word_bus),
    .cen       (cen),
    .shift_out (shift_out),
    .cset      (cset),
    .busy      (busy),
    .done      (done)
`ifdef CFG_CHAIN_LOADER_READBACK_EN
    ,
    .chain_in  (chain_in),
    .rb_valid  (rb_valid),
    .rb_data   (rb_data)
`endif
  );

  always #5 clk = ~clk;

`ifdef CFG_CHAIN_LOADER_READBACK_EN
  // 32-stage model of the tile column: advances only while the chain is enabled
  always @(posedge clk) begin
    if (rst)      dly <= '0;
    else if (cen) dly <= {dly[30:0], shift_out};
  end
  assign chain_in = dly[31];
`endif

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  logic        sb_bits[$];
  logic [31:0] sb_rb[$];
  int cyc = 0;
  int cen_cnt, runs, cset_cnt, done_cnt, rdy_cnt, rb_cnt;
  int first_cen_cyc, last_cen_cyc, cset_cyc, done_cyc, start_cyc;
  logic prev_cen = 1'b0;

  always @(posedge clk) cyc++;

  // Output monitor: pops expected serial bits and readback words as the DUT emits them
  always @(negedge clk) begin
    if (cen) begin
      cen_cnt++;
      if (cen_cnt == 1) first_cen_cyc = cyc;
      last_cen_cyc = cyc;
      if (!prev_cen) runs++;
      if (sb_bits.size() == 0) check("shift_extra", 64'(sb_bits.size()), 64'd1);
      else                     check("shift_out", 64'(shift_out), 64'(sb_bits.pop_front()));
    end
    prev_cen = cen;
    if (word_bus.word_ready) rdy_cnt++;
    if (cset) begin cset_cnt++; cset_cyc = cyc; end
    if (done) begin done_cnt++; done_cyc = cyc; end
    check("ready_and_cen", 64'(cen & word_bus.word_ready), 64'd0);
`ifdef CFG_CHAIN_LOADER_READBACK_EN
    if (rb_valid) begin
      rb_cnt++;
      if (sb_rb.size() == 0) check("rb_extra", 64'(sb_rb.size()), 64'd1);
      else                   check("rb_data", 64'(rb_data), 64'(sb_rb.pop_front()));
    end
`endif
  end

  task automatic clear_stats();
    cen_cnt = 0; runs = 0; cset_cnt = 0; done_cnt = 0; rdy_cnt = 0; rb_cnt = 0;
    first_cen_cyc = -1; last_cen_cyc = -1; cset_cyc = -1; done_cyc = -1;
    prev_cen = 1'b0;
  endtask

  task automatic push_bits(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) sb_bits.push_back(w[i]);
  endtask

  task automatic do_start(input int len);
    @(negedge clk);
    chain_len = CNT_W'(len);
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int stall);
    int n = 0;
    while (!word_bus.word_ready && n < 100) begin @(negedge clk); n++; end
    check("fetch_reached", 64'(word_bus.word_ready), 64'd1);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_cen", 64'(cen), 64'd0);
      check("stall_ready", 64'(word_bus.word_ready), 64'd1);
    end
    word_bus.word_valid = 1'b1;
    word_bus.word_data  = w;
    @(posedge clk); #1;
    word_bus.word_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 500);
    check("idle_reached", 64'(busy), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    word_bus.word_valid = 1'b0;
    word_bus.word_data  = '0;
    clear_stats();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 64'({cen, shift_out, cset, busy, done, word_bus.word_ready}), 64'd0);
`ifdef CFG_CHAIN_LOADER_READBACK_EN
    check("reset_rb", 64'({rb_valid, rb_data}), 64'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    // 40-bit load: full word, one bubble, 8-bit tail
    clear_stats();
    push_bits(32'hA5A5_A5A5, 32);
    push_bits(32'h0000_00FF, 8);
    do_start(40);
    send_word(32'hA5A5_A5A5, 0);
    send_word(32'h0000_00FF, 0);
    wait_idle();
    check("l40_cen_cnt", 64'(cen_cnt), 64'd40);
    check("l40_runs", 64'(runs), 64'd2);
    check("l40_span", 64'(last_cen_cyc - first_cen_cyc), 64'd40);
    check("l40_cset_cnt", 64'(cset_cnt), 64'd1);
    check("l40_done_cnt", 64'(done_cnt), 64'd1);
    check("l40_cset_time", 64'(cset_cyc), 64'(last_cen_cyc + 1));
    check("l40_done_time", 64'(done_cyc), 64'(cset_cyc + 1));
    check("l40_sb_left", 64'(sb_bits.size()), 64'd0);

    // Zero-length load: straight to SET
    clear_stats();
    do_start(0);
    wait_idle();
    check("l0_cset_time", 64'(cset_cyc), 64'(start_cyc + 1));
    check("l0_done_time", 64'(done_cyc), 64'(start_cyc + 2));
    check("l0_cen_cnt", 64'(cen_cnt), 64'd0);
    check("l0_ready_cnt", 64'(rdy_cnt), 64'd0);
    check("l0_cset_cnt", 64'(cset_cnt), 64'd1);

    // 64-bit load with the first word withheld 5 cycles
    clear_stats();
    push_bits(32'h0F0F_1234, 32);
    push_bits(32'hDEAD_BEEF, 32);
    do_start(64);
    send_word(32'h0F0F_1234, 5);
    send_word(32'hDEAD_BEEF, 0);
    wait_idle();
    check("l64_cen_cnt", 64'(cen_cnt), 64'd64);
    check("l64_runs", 64'(runs), 64'd2);
    check("l64_cset_cnt", 64'(cset_cnt), 64'd1);
    check("l64_done_cnt", 64'(done_cnt), 64'd1);
    check("l64_sb_left", 64'(sb_bits.size()), 64'd0);

    // Abort on the 10th SHIFT cycle, then a clean reload
    clear_stats();
    push_bits(32'h1357_9BDF, 32);
    do_start(32);
    send_word(32'h1357_9BDF, 0);
    repeat (10) @(negedge clk);
    check("abort_in_shift", 64'(cen), 64'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    sb_bits.delete();
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    repeat (5) @(negedge clk);
    check("abort_cen_cnt", 64'(cen_cnt), 64'd10);
    check("abort_cset_cnt", 64'(cset_cnt), 64'd0);
    check("abort_done_cnt", 64'(done_cnt), 64'd0);
    @(posedge clk); #1;
    clear_stats();
    push_bits(32'h2468_ACE1, 32);
    do_start(32);
    send_word(32'h2468_ACE1, 0);
    wait_idle();
    check("reload_cen_cnt", 64'(cen_cnt), 64'd32);
    check("reload_cset_cnt", 64'(cset_cnt), 64'd1);
    check("reload_done_cnt", 64'(done_cnt), 64'd1);
    check("reload_sb_left", 64'(sb_bits.size()), 64'd0);

    // start while busy is ignored; rst mid-SHIFT returns to idle
    clear_stats();
    push_bits(32'hCAFE_F00D, 32);
    do_start(64);
    send_word(32'hCAFE_F00D, 0);
    repeat (3) @(negedge clk);
    chain_len = CNT_W'(5);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("busy_start_cen", 64'(cen), 64'd1);
    check("busy_start_busy", 64'(busy), 64'd1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_outputs", 64'({cen, shift_out, cset, busy, done, word_bus.word_ready}), 64'd0);
    rst = 1'b0;
    sb_bits.delete();
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cset_cnt", 64'(cset_cnt), 64'd0);
    check("rst_done_cnt", 64'(done_cnt), 64'd0);
    @(posedge clk); #1;

`ifdef CFG_CHAIN_LOADER_READBACK_EN
    // Readback through a 32-stage loop: second captured word is the first one written
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_stats();
    push_bits(32'h1234_5678, 32);
    push_bits(32'h9ABC_DEF0, 32);
    sb_rb.push_back(32'h0000_0000);
    sb_rb.push_back(32'h1234_5678);
    do_start(64);
    send_word(32'h1234_5678, 0);
    send_word(32'h9ABC_DEF0, 0);
    wait_idle();
    repeat (2) @(negedge clk);
    check("rb_count", 64'(rb_cnt), 64'd2);
    check("rb_sb_left", 64'(sb_rb.size()), 64'd0);
    check("rb_cen_cnt", 64'(cen_cnt), 64'd64);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
